// File: rtl/sfq_dec_pkg.sv
// Shared types for the SFQ pulse decoder: FSM state and error code encodings.
package sfq_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_GUARD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_DOUBLE     = 2'd1,
    ERR_DATA_GUARD = 2'd2,
    ERR_CLK_GUARD  = 2'd3
  } err_e;

endpackage

// File: rtl/sfq_toggle_sync.sv
// Synchronizes one toggle-encoded line and emits a registered one-cycle pulse
// per level change; pulses are held off until the synchronizer holds real data.
module sfq_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_arm;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // r_arm fills with ones after reset so a line held high through reset
  // never looks like an edge while the chain flushes its reset zeros.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_arm   <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync[0] <= i_line;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_arm   <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      r_prev  <= w_synced;
      r_pulse <= r_arm[SYNC_STAGES] & (w_synced ^ r_prev);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sfq_pulse_decoder.sv
// Decodes toggle-encoded SFQ clock/data lines into bits with guard-window
// error detection and saturating bit/error counters.
//   state     | meaning
//   ST_IDLE   | waiting for the first clock pulse
//   ST_WINDOW | collecting data pulses for the current bit
//   ST_GUARD  | GUARD_CYCLES cycles after a clock pulse; any pulse is an error
module sfq_pulse_decoder
  import sfq_dec_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk,
  input  logic             sfq_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [1:0]       err_code,
  output logic             err_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]    GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [GW-1:0]    GUARD_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             w_clk_p;
  logic             w_data_p;
  logic             w_emit;
  logic             w_emit_bit;
  err_e             w_err;
  state_e           r_state;
  logic [GW-1:0]    r_guard_cnt;
  logic             r_seen;
  logic             r_bit_out;
  logic             r_bit_valid;
  err_e             r_err_code;
  logic             r_err_valid;
  logic [CNT_W-1:0] r_bit_count;
  logic [CNT_W-1:0] r_err_count;

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk(clk), .i_rst(rst), .i_line(sfq_clk), .o_pulse(w_clk_p)
  );

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .i_clk(clk), .i_rst(rst), .i_line(sfq_data), .o_pulse(w_data_p)
  );

  // A data pulse coinciding with a clock pulse is treated as a guard hit.
  always_comb begin
    w_err = ERR_NONE;
    case (r_state)
      ST_WINDOW: begin
        if (w_clk_p && w_data_p)    w_err = ERR_DATA_GUARD;
        else if (w_data_p && r_seen) w_err = ERR_DOUBLE;
      end
      ST_GUARD: begin
        if (w_clk_p)       w_err = ERR_CLK_GUARD;
        else if (w_data_p) w_err = ERR_DATA_GUARD;
      end
      default: w_err = ERR_NONE;
    endcase
  end

  assign w_emit     = w_clk_p && (r_state != ST_IDLE);
  assign w_emit_bit = (r_state == ST_WINDOW) && r_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_guard_cnt <= '0;
      r_seen      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_valid <= 1'b0;
      r_bit_count <= '0;
      r_err_count <= '0;
    end else begin
      r_bit_valid <= w_emit;
      r_err_valid <= (w_err != ERR_NONE);
      r_err_code  <= w_err;
      if (w_emit) r_bit_out <= w_emit_bit;
      if (w_emit && r_bit_count != CNT_MAX) r_bit_count <= r_bit_count + CNT_ONE;
      if ((w_err != ERR_NONE) && r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_ONE;
      case (r_state)
        ST_IDLE: begin
          if (w_clk_p) begin
            r_state     <= ST_GUARD;
            r_guard_cnt <= GUARD_LOAD;
          end
        end
        ST_WINDOW: begin
          if (w_clk_p) begin
            r_seen      <= 1'b0;
            r_state     <= ST_GUARD;
            r_guard_cnt <= GUARD_LOAD;
          end else if (w_data_p) begin
            r_seen <= 1'b1;
          end
        end
        ST_GUARD: begin
          if (w_clk_p)                r_guard_cnt <= GUARD_LOAD;
          else if (r_guard_cnt == '0) r_state     <= ST_WINDOW;
          else                        r_guard_cnt <= r_guard_cnt - GUARD_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign err_code  = r_err_code;
  assign err_valid = r_err_valid;
  assign bit_count = r_bit_count;
  assign err_count = r_err_count;

endmodule

// File: doc/sfq_pulse_decoder.md
SFQ_PULSE_DECODER -- requirements
Module: sfq_pulse_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on each toggle-encoded input.
REQ-002 SHALL have parameter GUARD_CYCLES, default 3: critical-timing window after a clock pulse, in clk cycles.
REQ-003 SHALL have parameter CNT_W, default 16: width of both counters.
REQ-004 clk  input  1  sampling clock; the block's only clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sfq_clk  input  1  toggle-encoded SFQ clock line; each level change is one clock pulse.
REQ-007 sfq_data  input  1  toggle-encoded data line from the upstream inverter output; each level change is one data pulse.
REQ-008 bit_out  output  1  decoded bit for the window that just closed.
REQ-009 bit_valid  output  1  one-cycle strobe qualifying bit_out.
REQ-010 err_code  output  2  0 none, 1 double data pulse, 2 data pulse in guard, 3 clock pulse in guard; valid with err_valid.
REQ-011 err_valid  output  1  one-cycle error strobe.
REQ-012 bit_count  output  CNT_W  number of bit_valid strobes, saturating.
REQ-013 err_count  output  CNT_W  number of err_valid strobes, saturating.

Function
REQ-014 Each input SHALL pass through SYNC_STAGES flops; a pulse is detected when the synchronized value differs from its registered previous value.
REQ-015 States SHALL be IDLE (before first clock pulse), WINDOW (collecting data), and GUARD (GUARD_CYCLES cycles after a clock pulse).
REQ-016 IDLE: data pulses ignored; clock pulse -> GUARD, no bit emitted.
REQ-017 WINDOW: data pulse sets the seen flag; a second data pulse in the same window -> err_code 1, seen stays 1; clock pulse -> emit bit_out = seen, clear seen, -> GUARD.
REQ-018 GUARD: a down-counter loads GUARD_CYCLES-1 on entry and -> WINDOW when it reaches 0; data pulse -> err_code 2, pulse discarded; clock pulse -> err_code 3, emit bit_out = 0, reload counter, stay GUARD.
REQ-019 Simultaneous data and clock pulse detected in the same cycle in WINDOW SHALL emit bit_out = seen from earlier pulses, flag err_code 2, and discard the data pulse.
REQ-020 Multiple error conditions in one cycle SHALL report the highest code (3 > 2 > 1), counting one error.
REQ-021 Latency: bit_valid and err_valid SHALL assert exactly SYNC_STAGES+1 clk cycles after the first rising clk edge that samples the causing input change.
REQ-022 bit_valid and err_valid SHALL each be high for exactly one cycle; bit_out SHALL hold its value until the next bit_valid.
REQ-023 bit_count and err_count SHALL increment on their strobes and saturate at all-ones without wrap.

Reset
REQ-024 rst high SHALL immediately force state IDLE, all synchronizer and previous-value flops 0, seen 0, guard counter 0, all outputs 0.
REQ-025 In the first cycle after rst deasserts, previous-value registers SHALL load the synchronized value without signalling a pulse, so a line held high through reset causes no false edge.
REQ-026 rst asserted mid-window SHALL discard the partial window with no strobe.

Structure
REQ-027 Package sfq_dec_pkg SHALL hold the state enum and the err_code enum constants.
REQ-028 Sub-module sfq_toggle_sync (synchronizer, previous-value register, arm flag, edge detect) SHALL be instantiated once per input.

Verification
REQ-029 rst release with sfq_clk=1, sfq_data=1 held -> no pulse detected, state IDLE, all outputs 0.
REQ-030 Clock toggle, wait 6 cycles, data toggle, wait 6, clock toggle -> bit_valid with bit_out=1 at SYNC_STAGES+1=3 cycles after the second clock sample, bit_count=1, err_count=0.
REQ-031 Two clock toggles 8 cycles apart with no data -> bit_out=0, bit_valid once, no error.
REQ-032 Data toggle 1 cycle after a clock toggle (GUARD_CYCLES=3) -> err_code=2, err_count=1, next bit_out=0.
REQ-033 Two data toggles 4 cycles apart in one window -> err_code=1 once, closing bit_out=1; clock toggles 2 cycles apart -> err_code=3, bit_out=0.
REQ-034 With CNT_W=2, 5 valid windows -> bit_count stays 3; rst mid-window -> no bit_valid, counters 0.
